// File: rtl/pulse_stretcher_pkg.sv
// Shared types and width helpers for the pulse stretcher and its counters.
package pulse_stretcher_pkg;

  // Output FSM: IDLE waits for an event, HIGH drives the level, GAP forces
  // a low spacer between replayed events.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int STATE_W = 2;

  // Width needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_ld_down_counter.sv
// Loadable down counter with a "last cycle" flag (count == 1).
// Load has priority over enable; the count stops at zero.
module pulse_stretcher_ld_down_counter
  import pulse_stretcher_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_last
);

  logic [W-1:0] r_count;

  // Count register: synchronous reset, load wins over decrement.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_last = (r_count == W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event strobes into fixed-length
// visible levels. Events arriving while busy are queued in a saturating
// pending counter and replayed with a low gap between them; with
// RETRIGGER set, an event during HIGH extends the current level instead.
//
// Interface semantics: i_pulse_in is a plain strobe with no handshake;
// every cycle it is sampled high at a rising edge counts as one event.
// All outputs are registered and change only on the rising edge.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter  int HOLD_CYCLES = 10,
  parameter  int GAP_CYCLES  = 5,
  parameter  int PEND_MAX    = 7,
  parameter  int RETRIGGER   = 0,
  localparam int PW          = $clog2(PEND_MAX + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pulse_in,
  input  logic          i_clr_ovf,
  output logic          o_out_level,
  output logic          o_busy,
  output logic [PW-1:0] o_pending,
  output logic          o_overflow,
  output state_e        o_state
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int GW = cnt_width(GAP_CYCLES);

  localparam logic [HW-1:0] HOLD_LD   = HW'(HOLD_CYCLES);
  localparam logic [GW-1:0] GAP_LD    = GW'(GAP_CYCLES);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_out_level;
  logic          r_busy;
  logic [PW-1:0] r_pending;
  logic          r_overflow;

  logic w_hold_load;
  logic w_hold_en;
  logic w_hold_last;
  logic w_gap_load;
  logic w_gap_en;
  logic w_gap_last;
  logic w_inc;
  logic w_dec;
  logic w_has_pend;
  logic w_full;
  logic w_drop;

  assign w_has_pend = (r_pending != '0);
  assign w_full     = (r_pending == PEND_FULL);
  // An event is only lost when the queue is full and nothing leaves it.
  assign w_drop     = w_inc && !w_dec && w_full;

  pulse_stretcher_ld_down_counter #(.W(HW)) u_hold_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_hold_load),
    .i_load_val (HOLD_LD),
    .i_en       (w_hold_en),
    .o_last     (w_hold_last)
  );

  pulse_stretcher_ld_down_counter #(.W(GW)) u_gap_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LD),
    .i_en       (w_gap_en),
    .o_last     (w_gap_last)
  );

  // Next-state, counter control and queue push/pop decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_load = 1'b0;
    w_hold_en   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_en    = 1'b0;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A queued event (left over from the last gap cycle) is replayed
        // first; a fresh strobe in the same cycle takes its queue slot.
        if (i_pulse_in || w_has_pend) begin
          w_state_nxt = ST_HIGH;
          w_hold_load = 1'b1;
          if (w_has_pend) begin
            w_dec = 1'b1;
            w_inc = i_pulse_in;
          end
        end
      end
      ST_HIGH: begin
        if ((RETRIGGER != 0) && i_pulse_in) begin
          w_hold_load = 1'b1;
        end else begin
          w_hold_en = 1'b1;
          w_inc     = i_pulse_in;
          if (w_hold_last) begin
            if (GAP_CYCLES > 0) begin
              w_state_nxt = ST_GAP;
              w_gap_load  = 1'b1;
            end else if (w_has_pend) begin
              w_hold_load = 1'b1;
              w_dec       = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        w_gap_en = 1'b1;
        w_inc    = i_pulse_in;
        if (w_gap_last) begin
          if (w_has_pend) begin
            w_state_nxt = ST_HIGH;
            w_hold_load = 1'b1;
            w_dec       = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, registered outputs, pending queue and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_out_level <= 1'b0;
      r_busy      <= 1'b0;
      r_pending   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_level <= (w_state_nxt == ST_HIGH);
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_inc && !w_dec && !w_full) begin
        r_pending <= r_pending + PW'(1);
      end else if (w_dec && !w_inc) begin
        r_pending <= r_pending - PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_out_level = r_out_level;
  assign o_busy      = r_busy;
  assign o_pending   = r_pending;
  assign o_overflow  = r_overflow;
  assign o_state     = r_state;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher. Three instances share clock/reset:
// dut_a (HOLD=4, GAP=2, PEND_MAX=3), dut_ret (same, RETRIGGER=1) and
// dut_g0 (GAP=0). Cycle c means the interval after input edge c-1.
module tb_pulse_stretcher;
  import pulse_stretcher_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   pulse_a;
  logic   pulse_ret;
  logic   pulse_g0;
  logic   clr_ovf;

  logic       a_out, a_busy, a_ovf;
  logic [1:0] a_pend;
  state_e     a_state;
  logic       ret_out, ret_busy, ret_ovf;
  logic [1:0] ret_pend;
  state_e     ret_state;
  logic       g0_out, g0_busy, g0_ovf;
  logic [1:0] g0_pend;
  state_e     g0_state;

  int n_vec = 0;
  int n_err = 0;
  int rises;
  logic prev_out;
  logic exp_out;
  int exp_pend;

  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_MAX(3), .RETRIGGER(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse_in(pulse_a), .i_clr_ovf(clr_ovf),
    .o_out_level(a_out), .o_busy(a_busy), .o_pending(a_pend),
    .o_overflow(a_ovf), .o_state(a_state)
  );

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_MAX(3), .RETRIGGER(1)) dut_ret (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse_in(pulse_ret), .i_clr_ovf(clr_ovf),
    .o_out_level(ret_out), .o_busy(ret_busy), .o_pending(ret_pend),
    .o_overflow(ret_ovf), .o_state(ret_state)
  );

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .PEND_MAX(3), .RETRIGGER(0)) dut_g0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pulse_in(pulse_g0), .i_clr_ovf(clr_ovf),
    .o_out_level(g0_out), .o_busy(g0_busy), .o_pending(g0_pend),
    .o_overflow(g0_ovf), .o_state(g0_state)
  );

  // Advance one edge; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pulse_a   = 1'b0;
    pulse_ret = 1'b0;
    pulse_g0  = 1'b0;
    clr_ovf   = 1'b0;
    step();
    step();

    // Reset state
    chk("rst a_out",  32'(a_out),  0);
    chk("rst a_busy", 32'(a_busy), 0);
    chk("rst a_pend", 32'(a_pend), 0);
    chk("rst a_ovf",  32'(a_ovf),  0);
    chk("rst a_state",   32'(a_state),   32'(ST_IDLE));
    chk("rst ret_state", 32'(ret_state), 32'(ST_IDLE));
    chk("rst g0_state",  32'(g0_state),  32'(ST_IDLE));
    chk("rst g0_ovf",    32'(g0_ovf),    0);
    rst_n = 1'b1;
    step();

    // Single pulse: high cycles 1-4, busy 1-6, idle at 7
    pulse_a = 1'b1;
    step();
    pulse_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t1 out c%0d", c),  32'(a_out),  32'(c <= 4));
      chk($sformatf("t1 busy c%0d", c), 32'(a_busy), 32'(c <= 6));
      step();
    end
    chk("t1 state idle", 32'(a_state), 32'(ST_IDLE));

    // Pulses at edges 0,2,3: highs 1-4, 7-10, 13-16; queue 1,2,...,0
    for (int e = 0; e <= 19; e++) begin
      pulse_a = (e == 0) || (e == 2) || (e == 3);
      step();
      pulse_a = 1'b0;
      exp_out = ((e + 1) <= 4) || ((e + 1) >= 7 && (e + 1) <= 10) ||
                ((e + 1) >= 13 && (e + 1) <= 16);
      exp_pend = ((e + 1) < 3) ? 0 : ((e + 1) < 4) ? 1 : ((e + 1) < 7) ? 2 :
                 ((e + 1) < 13) ? 1 : 0;
      chk($sformatf("t2 out c%0d", e + 1),  32'(a_out),  32'(exp_out));
      chk($sformatf("t2 pend c%0d", e + 1), 32'(a_pend), 32'(exp_pend));
    end
    chk("t2 busy end", 32'(a_busy), 0);

    // pulse_in high for edges 0..7. Edges 1-3 fill the queue, 4-5 drop,
    // edge 6 is accepted because a replay pops in the same cycle, edge 7
    // drops: one direct + four replayed = five highs in total.
    rises    = 0;
    prev_out = a_out;
    for (int e = 0; e <= 31; e++) begin
      pulse_a = (e <= 7);
      step();
      pulse_a = 1'b0;
      if (a_out && !prev_out) rises++;
      prev_out = a_out;
      if (e + 1 == 4) begin
        chk("t3 pend c4", 32'(a_pend), 3);
        chk("t3 ovf c4",  32'(a_ovf),  0);
      end
      if (e + 1 == 5) begin
        chk("t3 pend c5", 32'(a_pend), 3);
        chk("t3 ovf c5",  32'(a_ovf),  1);
      end
      if (e + 1 == 7)  chk("t3 pend c7",  32'(a_pend), 3);
      if (e + 1 == 13) chk("t3 pend c13", 32'(a_pend), 2);
      if (e + 1 == 19) chk("t3 pend c19", 32'(a_pend), 1);
      if (e + 1 == 25) chk("t3 pend c25", 32'(a_pend), 0);
    end
    chk("t3 highs", 32'(rises), 5);
    chk("t3 idle", 32'(a_state), 32'(ST_IDLE));
    chk("t3 ovf sticky", 32'(a_ovf), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t3 ovf cleared", 32'(a_ovf), 0);

    // RETRIGGER: pulses at 0 and 3 -> high 1-7, gap 8-9, queue untouched
    for (int e = 0; e <= 11; e++) begin
      pulse_ret = (e == 0) || (e == 3);
      step();
      pulse_ret = 1'b0;
      chk($sformatf("t4 out c%0d", e + 1),  32'(ret_out),  32'((e + 1) <= 7));
      chk($sformatf("t4 busy c%0d", e + 1), 32'(ret_busy), 32'((e + 1) <= 9));
      chk($sformatf("t4 pend c%0d", e + 1), 32'(ret_pend), 0);
    end

    // GAP_CYCLES=0: pulses at 0 and 1 merge into one level, cycles 1-8
    for (int e = 0; e <= 10; e++) begin
      pulse_g0 = (e <= 1);
      step();
      pulse_g0 = 1'b0;
      chk($sformatf("t5 out c%0d", e + 1),  32'(g0_out),  32'((e + 1) <= 8));
      chk($sformatf("t5 busy c%0d", e + 1), 32'(g0_busy), 32'((e + 1) <= 8));
      if (e + 1 == 2) chk("t5 pend c2", 32'(g0_pend), 1);
      if (e + 1 == 5) chk("t5 pend c5", 32'(g0_pend), 0);
    end

    // Event on the last gap cycle with empty queue: IDLE at 7 with it
    // queued, replayed as highs 8-11.
    for (int e = 0; e <= 12; e++) begin
      pulse_a = (e == 0) || (e == 6);
      step();
      pulse_a = 1'b0;
      exp_out = ((e + 1) <= 4) || ((e + 1) >= 8 && (e + 1) <= 11);
      chk($sformatf("t6 out c%0d", e + 1), 32'(a_out), 32'(exp_out));
      if (e + 1 == 7) begin
        chk("t6 state c7", 32'(a_state), 32'(ST_IDLE));
        chk("t6 pend c7",  32'(a_pend),  1);
        chk("t6 busy c7",  32'(a_busy),  0);
      end
      if (e + 1 == 8) chk("t6 pend c8", 32'(a_pend), 0);
    end
    step();
    step();
    chk("t6 idle", 32'(a_state), 32'(ST_IDLE));

    // Reset during HIGH with two queued events, then restart
    for (int e = 0; e <= 2; e++) begin
      pulse_a = 1'b1;
      step();
    end
    pulse_a = 1'b0;
    chk("t7 pend before rst", 32'(a_pend), 2);
    chk("t7 out before rst",  32'(a_out),  1);
    rst_n = 1'b0;
    step();
    chk("t7 rst out",   32'(a_out),   0);
    chk("t7 rst pend",  32'(a_pend),  0);
    chk("t7 rst busy",  32'(a_busy),  0);
    chk("t7 rst ovf",   32'(a_ovf),   0);
    chk("t7 rst state", 32'(a_state), 32'(ST_IDLE));
    rst_n   = 1'b1;
    pulse_a = 1'b1;
    step();
    pulse_a = 1'b0;
    chk("t7 restart out",  32'(a_out),  1);
    chk("t7 restart busy", 32'(a_busy), 1);
    chk("t7 restart pend", 32'(a_pend), 0);
    step();
    step();
    step();
    chk("t7 restart c4 out", 32'(a_out), 1);
    step();
    chk("t7 restart c5 out", 32'(a_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
